cpu_bus_responder: RTL
======================

// Module: cpu_bus_responder
// PURPOSE
// - Target end of the CPU byte bus (mem_a/mem_dout/mem_wr in, mem_din out): 128 KB RAM plus memory-mapped UART I/O.
// - Answers every CPU read with a registered byte on the next cycle and absorbs writes in one cycle.
// - Buffers UART TX bytes in a FIFO, drives io_buffer_full back to the CPU, pops UART RX on read.
// - Provides the cycle-counter and program-stop ports.
// PARAMETERS
// - RAM_AW      17  RAM byte-address width (2^17 = 128 KB)
// - TXQ_DEPTH   8   TX FIFO entries, power of 2, >= 4
// - TXQ_AW      3   log2(TXQ_DEPTH)
// PORTS
// - clk_in         in   1   system clock
// - rst_in         in   1   reset, asynchronous, active-low
// - mem_a          in   32  byte address from CPU; only [17:0] decoded
// - mem_dout       in   8   write data from CPU
// - mem_wr         in   1   1 = write, 0 = read, sampled every cycle
// - mem_din        out  8   read data to CPU, valid the cycle after the address
// - io_buffer_full out  1   TX FIFO almost full; CPU must not issue 0x30000 writes
// - tx_data        out  8   byte to UART transmitter
// - tx_valid       out  1   tx_data valid; transfer when tx_valid & tx_ready
// - tx_ready       in   1   UART transmitter accepts byte
// - rx_data        in   8   byte from UART receiver
// - rx_valid       in   1   rx_data valid
// - rx_pop         out  1   1-cycle pulse consuming rx_data
// - prog_stop      out  1   sticky; set by a 0x30004 write
// - txq_overflow   out  1   sticky; a TX write was dropped because the FIFO was full
// BEHAVIOUR
// - Reset (rst_in=0, any time, async): mem_din=0, tx_valid=0, rx_pop=0, prog_stop=0, txq_overflow=0, io_buffer_full=0.
// - Reset also clears FIFO pointers/count, cycle counter and snapshot. RAM contents are not cleared.
// - Decode: mem_a[17:16]!=2'b11 -> RAM at mem_a[RAM_AW-1:0]; 2'b11 -> I/O, decoded on mem_a[2:0].
// - RAM read: mem_din <= ram[a] at the next clk edge. Write: ram[a] <= mem_dout this edge.
// - RAM read of an address written on the previous cycle returns the new data.
// - I/O read 0x30000: if rx_valid, mem_din <= rx_data and rx_pop=1 for that cycle; otherwise mem_din <= 0 and no pop.
// - I/O read 0x30004..0x30007: returns byte mem_a[1:0] of cnt_snap (little-endian).
// - cnt_snap <= cycle_cnt on each read of 0x30004, so 0x30005..7 read a consistent dword.
// - cycle_cnt: 32-bit, +1 every clock after reset, wraps 0xFFFFFFFF -> 0.
// - Other I/O reads return 0.
// - I/O write 0x30000: data 0x00 is ignored. Otherwise push onto the FIFO; if the FIFO is full, drop the byte and set txq_overflow.
// - I/O write 0x30004: set prog_stop and push 0x00 (terminator) regardless of value. Once prog_stop=1, further 0x30004 writes are ignored.
// - FIFO: tx_valid = count!=0; tx_data = head entry. Pop on tx_valid & tx_ready.
// - Simultaneous push and pop keeps count unchanged and is legal when full.
// - Pointers wrap modulo TXQ_DEPTH.
// - io_buffer_full = registered (count >= TXQ_DEPTH-2). The 2-entry margin covers CPU pipeline skid.
// - mem_din holds its last value on cycles with a write or no I/O/RAM read effect. Reads never change RAM/FIFO state, except that a 0x30000 read pops RX.
// CONFIGURATION
// - Macro CPU_BUS_RESP_CYCLE_CNT_EN.
//   - Defined: cycle_cnt/cnt_snap as above.
//   - Undefined: counter and snapshot are not built; reads of 0x30004..0x30007 return 0x00. All other behaviour is unchanged.
// TESTING
// - RAM: write 0xA5 @0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read address.
// - TX: writes 0x48,0x00,0x69 @0x30000 with tx_ready=1 -> tx stream 0x48,0x69; 0x00 dropped.
// - Backpressure: tx_ready=0, 6 writes, TXQ_DEPTH=8 -> io_buffer_full=1 after the 6th.
//   - 3 more writes -> 9th dropped, txq_overflow=1.
//   - Release tx_ready -> 8 bytes in order.
// - Stop: write 0x30004 -> prog_stop=1, tx emits 0x00. A second 0x30004 write -> no extra byte.
// - Counter: 10 cycles after reset, read 0x30004 then 0x30005..7 -> bytes form 10 (+/-pipeline offset fixed), little-endian.
//   - Without macro -> all four bytes 0.
// - RX/reset: rx_valid=1, rx_data=0x3C, read 0x30000 -> mem_din=0x3C, rx_pop pulse.
//   - rx_valid=0 -> mem_din=0, no pop.
//   - Assert rst_in low mid-burst -> all outputs 0 asynchronously, FIFO empty.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: target side of the CPU byte bus.
// 128 KB RAM below 0x30000, UART I/O at 0x30000..0x30007, TX byte FIFO,
// RX pop on read, sticky program-stop and TX-overflow flags.
// Optional free-running cycle counter with read snapshot, built only when
// the macro CPU_BUS_RESP_CYCLE_CNT_EN is defined.
module cpu_bus_responder #(
    parameter int RAM_AW    = 17,
    parameter int TXQ_DEPTH = 8,
    parameter int TXQ_AW    = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        prog_stop,
    output logic        txq_overflow
);
    localparam logic [TXQ_AW:0]   DEPTH_C  = (TXQ_AW+1)'(TXQ_DEPTH);
    localparam logic [TXQ_AW:0]   ALMOST_C = (TXQ_AW+1)'(TXQ_DEPTH - 2);
    localparam logic [TXQ_AW:0]   CNT_ONE  = (TXQ_AW+1)'(1);
    localparam logic [TXQ_AW-1:0] PTR_ONE  = TXQ_AW'(1);

    // Address decode: bits above 17 are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a[31:18];

    logic is_io, io_data, io_stop, io_cnt, ram_we;
    assign is_io   = (mem_a[17:16] == 2'b11);
    assign io_data = is_io && (mem_a[2:0] == 3'd0);
    assign io_stop = is_io && (mem_a[2:0] == 3'd4);
    assign io_cnt  = is_io && mem_a[2];
    assign ram_we  = mem_wr && !is_io;

    // RAM storage; contents deliberately survive reset.
    logic [7:0] ram_mem [2**RAM_AW];
    always_ff @(posedge clk_in) begin
        if (ram_we) ram_mem[mem_a[RAM_AW-1:0]] <= mem_dout;
    end

    logic [7:0] cnt_rd_byte;
`ifdef CPU_BUS_RESP_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, cnt_snap_q, cnt_snap_d;

    // Counter runs every cycle; a read of 0x30004 snapshots it so that the
    // following byte reads see one consistent dword.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        cnt_snap_d  = cnt_snap_q;
        if (!mem_wr && io_stop) cnt_snap_d = cycle_cnt_q;
    end

    // Counter and snapshot registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt_q <= 32'd0;
            cnt_snap_q  <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            cnt_snap_q  <= cnt_snap_d;
        end
    end

    // Byte 0 comes from the value being captured this cycle.
    assign cnt_rd_byte = cnt_snap_d[{mem_a[1:0], 3'b000} +: 8];
`else
    assign cnt_rd_byte = 8'h00;
`endif

    // TX FIFO control
    logic [TXQ_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TXQ_AW:0]   cnt_q, cnt_d;
    logic              prog_stop_q, prog_stop_d;
    logic              txq_overflow_q, txq_overflow_d;
    logic              io_buffer_full_q, io_buffer_full_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic [7:0]        txq_mem [TXQ_DEPTH];

    logic stop_wr, push_req, txq_full, txq_pop, txq_push, txq_drop, rx_pop_c;
    logic [7:0] push_data;
    assign stop_wr   = mem_wr && io_stop && !prog_stop_q;
    assign push_req  = (mem_wr && io_data && (mem_dout != 8'h00)) || stop_wr;
    assign push_data = io_stop ? 8'h00 : mem_dout;
    assign txq_full  = (cnt_q == DEPTH_C);
    assign tx_valid  = (cnt_q != '0);
    assign tx_data   = txq_mem[rd_ptr_q];
    assign txq_pop   = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so push-while-full is legal then.
    assign txq_push  = push_req && (!txq_full || txq_pop);
    assign txq_drop  = push_req && txq_full && !txq_pop;

    // FIFO storage, no reset needed: only entries below count are visible.
    always_ff @(posedge clk_in) begin
        if (txq_push) txq_mem[wr_ptr_q] <= push_data;
    end

    // Read data mux and RX pop; writes leave mem_din untouched.
    always_comb begin
        mem_din_d = mem_din_q;
        rx_pop_c  = 1'b0;
        if (!mem_wr) begin
            if (!is_io) begin
                mem_din_d = ram_mem[mem_a[RAM_AW-1:0]];
            end else if (io_data) begin
                mem_din_d = rx_valid ? rx_data : 8'h00;
                rx_pop_c  = rx_valid;
            end else if (io_cnt) begin
                mem_din_d = cnt_rd_byte;
            end else begin
                mem_din_d = 8'h00;
            end
        end
    end

    // FIFO pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        prog_stop_d    = prog_stop_q;
        txq_overflow_d = txq_overflow_q;
        if (txq_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (txq_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({txq_push, txq_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (txq_drop) txq_overflow_d = 1'b1;
        if (stop_wr)  prog_stop_d    = 1'b1;
        // Registered from next count so the flag tracks occupancy exactly.
        io_buffer_full_d = (cnt_d >= ALMOST_C);
    end

    // State registers with async active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            prog_stop_q      <= 1'b0;
            txq_overflow_q   <= 1'b0;
            io_buffer_full_q <= 1'b0;
            mem_din_q        <= 8'h00;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            prog_stop_q      <= prog_stop_d;
            txq_overflow_q   <= txq_overflow_d;
            io_buffer_full_q <= io_buffer_full_d;
            mem_din_q        <= mem_din_d;
        end
    end

    assign mem_din        = mem_din_q;
    assign prog_stop      = prog_stop_q;
    assign txq_overflow   = txq_overflow_q;
    assign io_buffer_full = io_buffer_full_q;
    // Pop is combinational with the read; forced low while in reset.
    assign rx_pop         = rx_pop_c && rst_in;
endmodule
